// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared constants, state types and payload encoder for the UART packet link
//
// Purpose: definitions common to the packet transmitter, its byte serializer
//          and the receive-side loader.
// Contents:
//   START_BYTE / STOP_BYTE : framing bytes (0x55 / 0xAA)
//   ADDR_W / DATA_W        : word field widths (10 / 12)
//   pkt_state_t            : packet sequencer states
//   ser_state_t            : 8N1 serializer states
//   encode_payload()       : splits an address/data word into four 6-bit payload bytes
package uart_pkt_pkg;

    localparam logic [7:0] START_BYTE = 8'h55;
    localparam logic [7:0] STOP_BYTE  = 8'hAA;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int WORD_W = ADDR_W + DATA_W;

    typedef enum logic {
        PKT_IDLE,
        PKT_SEND
    } pkt_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    // Element [0] is the first payload byte on the wire.
    typedef logic [3:0][7:0] payload_t;

    // Every payload byte carries at most 6 bits with the top two bits clear,
    // so it can never be mistaken for 0x55 or 0xAA by the receiver.
    function automatic payload_t encode_payload(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data);
        payload_t p;
        p[0] = {4'b0000, addr[9:6]};
        p[1] = {2'b00, addr[5:0]};
        p[2] = {2'b00, data[11:6]};
        p[3] = {2'b00, data[5:0]};
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - byte-level 8N1 UART transmitter with valid/ready input
//
// Purpose: shifts one byte out as start bit, 8 data bits LSB first, stop bit,
//          each bit CLK_FREQ/BAUD clock cycles long.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_data   in   byte to send
//   i_valid  in   i_data is offered this cycle
//   o_ready  out  serializer idle; a byte is taken on an edge with i_valid & o_ready
//   o_tx     out  serial line, idle high
module uart_tx_serializer
    import uart_pkt_pkg::*;
#(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // STOP hands over one cycle early: the IDLE cycle that follows is the
    // final cycle of the stop bit, and a waiting byte is loaded at its end,
    // so the stop bit is exactly CLKS_PER_BIT long even back-to-back.
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;

    assign o_ready = (r_state == SER_IDLE);
    assign o_tx    = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SER_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    r_tx <= 1'b1;
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_state <= SER_START;
                    end
                end

                SER_START: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= SER_DATA;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end

                SER_DATA: begin
                    if (r_baud == BIT_LAST) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= SER_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end

                SER_STOP: begin
                    if (r_baud == STOP_LAST) begin
                        r_baud  <= '0;
                        r_state <= SER_IDLE;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= SER_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_packet_tx.sv
// rtl/uart_packet_tx.sv - buffers address/data words and sends each as a framed 6-byte UART packet
//
// Purpose: word FIFO + packet sequencer in front of an 8N1 serializer.
//          Packet on the wire: 0x55, b0, b1, b2, b3, 0xAA.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset; aborts any packet, empties the FIFO
//   i_word_addr   in   10-bit address of the word to send
//   i_word_data   in   12-bit data of the word to send
//   i_word_valid  in   word offered this cycle
//   o_word_ready  out  FIFO not full; word taken on an edge with valid & ready
//   o_tx          out  serial line, idle high
//   o_busy        out  FIFO non-empty or packet in flight
//   o_pkt_done    out  one-cycle pulse as the last byte of a packet finishes
module uart_packet_tx
    import uart_pkt_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_word_addr,
    input  logic [DATA_W-1:0] i_word_data,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_pkt_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    pkt_state_t        r_pkt_state;
    logic [2:0]        r_byte_idx;
    logic [WORD_W-1:0] r_hold;
    logic              r_last_inflight;

    logic              w_push;
    logic              w_pop;
    logic              w_ser_ready;
    logic              w_ser_valid;
    logic              w_ser_accept;
    logic [7:0]        w_ser_byte;
    payload_t          w_payload;

    assign o_word_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push       = i_word_valid & o_word_ready;
    assign w_pop        = (r_pkt_state == PKT_IDLE) && (r_count != '0);

    // Storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {i_word_addr, i_word_data};
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet sequencer
    // ------------------------------------------------------------------
    assign w_payload    = encode_payload(r_hold[WORD_W-1:DATA_W], r_hold[DATA_W-1:0]);
    assign w_ser_valid  = (r_pkt_state == PKT_SEND);
    assign w_ser_accept = w_ser_valid & w_ser_ready;

    always_comb begin
        w_ser_byte = STOP_BYTE;
        case (r_byte_idx)
            3'd0:    w_ser_byte = START_BYTE;
            3'd1:    w_ser_byte = w_payload[0];
            3'd2:    w_ser_byte = w_payload[1];
            3'd3:    w_ser_byte = w_payload[2];
            3'd4:    w_ser_byte = w_payload[3];
            default: w_ser_byte = STOP_BYTE;
        endcase
    end

    // r_last_inflight marks that the STOP byte has been handed to the
    // serializer; the serializer's return to idle then ends the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_state     <= PKT_IDLE;
            r_byte_idx      <= '0;
            r_hold          <= '0;
            r_last_inflight <= 1'b0;
        end else begin
            case (r_pkt_state)
                PKT_IDLE: begin
                    if (w_pop) begin
                        r_hold      <= r_fifo[r_rd_ptr];
                        r_byte_idx  <= '0;
                        r_pkt_state <= PKT_SEND;
                    end
                end

                PKT_SEND: begin
                    if (w_ser_accept) begin
                        if (r_byte_idx == 3'd5) begin
                            r_byte_idx  <= '0;
                            r_pkt_state <= PKT_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                end

                default: r_pkt_state <= PKT_IDLE;
            endcase

            if (w_ser_accept && (r_byte_idx == 3'd5)) begin
                r_last_inflight <= 1'b1;
            end else if (w_ser_ready) begin
                r_last_inflight <= 1'b0;
            end
        end
    end

    assign o_pkt_done = r_last_inflight & w_ser_ready;
    assign o_busy     = (r_count != '0) || (r_pkt_state == PKT_SEND)
                        || (r_last_inflight && !w_ser_ready);

    // ------------------------------------------------------------------
    // Byte serializer
    // ------------------------------------------------------------------
    uart_tx_serializer #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_serializer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_ser_byte),
        .i_valid (w_ser_valid),
        .o_ready (w_ser_ready),
        .o_tx    (o_tx)
    );

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb/tb_uart_packet_tx.sv - scoreboard bench for uart_packet_tx with a decoding line monitor
module tb_uart_packet_tx;

    localparam int CPB = 8;
    localparam int PERIOD = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  i_word_addr;
    logic [11:0] i_word_data;
    logic        i_word_valid;
    logic        o_word_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_pkt_done;

    always #(PERIOD / 2) clk = ~clk;

    uart_packet_tx #(
        .CLK_FREQ   (8),
        .BAUD       (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_word_addr  (i_word_addr),
        .i_word_data  (i_word_data),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_pkt_done   (o_pkt_done)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [7:0] exp_q[$];
    time starts_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: packet byte idx of a word, straight from the encoding rules.
    function automatic logic [7:0] model_byte(input int addr, input int data, input int idx);
        case (idx)
            0:       return 8'h55;
            1:       return 8'(addr / 64);
            2:       return 8'(addr % 64);
            3:       return 8'(data / 64);
            4:       return 8'(data % 64);
            default: return 8'hAA;
        endcase
    endfunction

    // Drive a word from the falling edge, wait for ready, let one rising edge
    // accept it, then drop valid 1 time unit later.
    task automatic push(input logic [9:0] a, input logic [11:0] d);
        int n;
        n = 0;
        @(negedge clk);
        i_word_addr  = a;
        i_word_data  = d;
        i_word_valid = 1'b1;
        while (o_word_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_timeout", (n >= 2000), 0);
        @(posedge clk);
        for (int i = 0; i < 6; i++) exp_q.push_back(model_byte(int'(a), int'(d), i));
        exp_pulses++;
        #1 i_word_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n >= 5000), 0);
        repeat (20) @(negedge clk);
    endtask

    always @(negedge clk) if (o_pkt_done === 1'b1) pulses++;

    // Line monitor: decodes every 8N1 frame at bit centres and scores it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_tx === 1'b0) begin
                logic [9:0] frame;
                logic [7:0] e;
                bit aborted;
                time t0;
                frame = '0;
                aborted = 0;
                t0 = $time;
                for (int k = 0; k < 76; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if (k % 8 == 3) frame[k / 8] = o_tx;
                end
                if (!aborted) begin
                    starts_q.push_back(t0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got frame %0h expected no byte", frame);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame", {22'd0, frame}, {22'd0, 1'b1, e, 1'b0});
                    end
                end
            end
        end
    end

    initial begin
        int mism, npd, busy_at, busy_before, prev_busy, ncontig, eb, bi, k;
        logic [7:0] wb;
        rst_n        = 1'b0;
        i_word_valid = 1'b0;
        i_word_addr  = '0;
        i_word_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", o_tx, 1);
        chk("reset_ready", o_word_ready, 1);
        chk("reset_busy", o_busy, 0);
        chk("reset_pkt_done", o_pkt_done, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word: latency, full 480-cycle waveform, done/busy relation.
        push(10'h3FF, 12'hABC);
        chk("lat_accept_edge", o_tx, 1);
        @(posedge clk);
        #1 chk("lat_pop_edge", o_tx, 1);
        mism = 0; npd = 0; busy_at = -1; busy_before = -1; prev_busy = 1;
        for (int j = 0; j < 490; j++) begin
            @(posedge clk);
            #1;
            if (j < 480) begin
                bi = j / 80;
                k  = (j % 80) / 8;
                wb = model_byte(10'h3FF, 12'hABC, bi);
                if (k == 0) eb = 0;
                else if (k == 9) eb = 1;
                else eb = int'(wb[k-1]);
            end else begin
                eb = 1;
            end
            if (j == 0) chk("latency_fall", o_tx, 0);
            if (o_tx !== 1'(eb)) mism++;
            if (o_pkt_done === 1'b1) begin
                if (npd == 0) begin
                    busy_at = int'(o_busy);
                    busy_before = prev_busy;
                end
                npd++;
            end
            prev_busy = int'(o_busy);
        end
        chk("wave_mismatches", mism, 0);
        chk("single_pkt_done_count", npd, 1);
        chk("busy_at_done", busy_at, 0);
        chk("busy_before_done", busy_before, 1);
        wait_idle("idle_t1");
        chk("queue_empty_t1", exp_q.size(), 0);

        // Six consecutive random words: backpressure and contiguous packets.
        starts_q.delete();
        for (int w = 0; w < 6; w++) begin
            push(10'($urandom), 12'($urandom));
            if (w == 4) chk("ready_after_5th", o_word_ready, 0);
        end
        wait_idle("idle_t3");
        chk("queue_empty_t3", exp_q.size(), 0);
        chk("byte_count_t3", starts_q.size(), 36);
        ncontig = 0;
        for (int i = 1; i < starts_q.size(); i++)
            if (starts_q[i] - starts_q[i-1] != CPB * 10 * PERIOD) ncontig++;
        chk("contiguous_bytes", ncontig, 0);

        // Values whose raw fields resemble framing bytes.
        push(10'h155, 12'h2AA);
        wait_idle("idle_t4");
        chk("queue_empty_t4", exp_q.size(), 0);

        // Reset in the middle of b2 with a second word still queued.
        push(10'($urandom), 12'($urandom));
        push(10'($urandom), 12'($urandom));
        @(posedge clk);
        #1 chk("rst_pkt_started", o_tx, 0);
        repeat (244) @(posedge clk);
        #1 chk("rst_in_b2_start_bit", o_tx, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_high", o_tx, 1);
        chk("rst_ready", o_word_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_pkt_done", o_pkt_done, 0);
        exp_q.delete();
        exp_pulses -= 2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_line_idle", o_tx, 1);
        push(10'($urandom), 12'($urandom));
        wait_idle("idle_t5");
        chk("queue_empty_t5", exp_q.size(), 0);

        // Push coinciding with a pop while three words are queued.
        push(10'($urandom), 12'($urandom));
        for (int w = 0; w < 3; w++) push(10'($urandom), 12'($urandom));
        repeat (399) @(posedge clk);
        push(10'($urandom), 12'($urandom));
        chk("push_on_pop_ready", o_word_ready, 1);
        push(10'($urandom), 12'($urandom));
        chk("count_after_push_on_pop", o_word_ready, 0);
        wait_idle("idle_t6");
        chk("queue_empty_t6", exp_q.size(), 0);

        chk("pkt_done_total", pulses, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
